// File: rtl/bus_arbiter.sv
// ============================================================================
//  Module   : bus_arbiter
//  Purpose  : Round-robin sharing of the system bus between the CPU and two
//             DMA-style masters, with a CPU bus_request/bus_ack handshake.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_arbiter #(
  parameter int CPU_MIN_SLOTS = 4,
  parameter int ADDR_W        = 24
) (
  input  logic                clk,
  input  logic                clk_ce,
  input  logic                reset,
  input  logic [1:0]          req,
  output logic [1:0]          gnt,
  output logic                cpu_bus_request,
  input  logic                cpu_bus_ack,
  input  logic [ADDR_W-1:0]   cpu_address,
  input  logic [7:0]          cpu_data,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic [1:0]          cpu_bus_status,
  input  logic [2*ADDR_W-1:0] m_address,
  input  logic [15:0]         m_data,
  input  logic [1:0]          m_read,
  input  logic [1:0]          m_write,
  input  logic [3:0]          m_bus_status,
  output logic [ADDR_W-1:0]   bus_address,
  output logic [7:0]          bus_data,
  output logic                bus_read,
  output logic                bus_write,
  output logic [1:0]          bus_status,
  output logic [1:0]          owner
);

  localparam int SLOT_W = (CPU_MIN_SLOTS > 0) ? $clog2(CPU_MIN_SLOTS + 1) : 1;

  typedef enum logic [1:0] {
    CPU_OWN  = 2'd0,
    WAIT_ACK = 2'd1,
    GRANT    = 2'd2,
    TURN     = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                cpu_bus_request_q, cpu_bus_request_d;
  logic [1:0]          owner_q, owner_d;
  logic                last_served_q, last_served_d;  // 0 = M0, 1 = M1
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [ADDR_W-1:0]   addr_hold_q, addr_hold_d;
  logic [7:0]          data_hold_q, data_hold_d;
  logic                win;

  always_comb begin
    state_d           = state_q;
    gnt_d             = gnt_q;
    cpu_bus_request_d = cpu_bus_request_q;
    owner_d           = owner_q;
    last_served_d     = last_served_q;
    slot_d            = slot_q;
    win               = (req == 2'b11) ? ~last_served_q : req[1];

    case (state_q)
      CPU_OWN: begin
        if ((req != 2'b00) && (slot_q == '0)) begin
          cpu_bus_request_d = 1'b1;
          state_d           = WAIT_ACK;
        end else if (slot_q != '0) begin
          slot_d = slot_q - SLOT_W'(1);
        end
      end
      WAIT_ACK: begin
        if (req == 2'b00) begin
          cpu_bus_request_d = 1'b0;
          state_d           = CPU_OWN;
        end else if (cpu_bus_ack) begin
          gnt_d         = win ? 2'b10 : 2'b01;
          owner_d       = win ? 2'd2 : 2'd1;
          last_served_d = win;
          state_d       = GRANT;
        end
      end
      GRANT: begin
        // Tenure ends only when the owning master drops its request.
        if (!req[last_served_q]) begin
          gnt_d   = 2'b00;
          owner_d = 2'd3;
          state_d = TURN;
        end
      end
      TURN: begin
        if (req[~last_served_q] && (CPU_MIN_SLOTS == 0)) begin
          gnt_d         = last_served_q ? 2'b01 : 2'b10;
          owner_d       = last_served_q ? 2'd1 : 2'd2;
          last_served_d = ~last_served_q;
          state_d       = GRANT;
        end else begin
          cpu_bus_request_d = 1'b0;
          owner_d           = 2'd0;
          slot_d            = SLOT_W'(CPU_MIN_SLOTS);
          state_d           = CPU_OWN;
        end
      end
      default: state_d = CPU_OWN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= CPU_OWN;
      gnt_q             <= 2'b00;
      cpu_bus_request_q <= 1'b0;
      owner_q           <= 2'd0;
      last_served_q     <= 1'b1;
      slot_q            <= '0;
    end else if (clk_ce) begin
      state_q           <= state_d;
      gnt_q             <= gnt_d;
      cpu_bus_request_q <= cpu_bus_request_d;
      owner_q           <= owner_d;
      last_served_q     <= last_served_d;
      slot_q            <= slot_d;
    end
  end

  // Snapshot of the last driven address/data, replayed during turnaround.
  assign addr_hold_d = (owner_q != 2'd3) ? bus_address : addr_hold_q;
  assign data_hold_d = (owner_q != 2'd3) ? bus_data    : data_hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_hold_q <= '0;
      data_hold_q <= '0;
    end else begin
      addr_hold_q <= addr_hold_d;
      data_hold_q <= data_hold_d;
    end
  end

  always_comb begin
    bus_address = cpu_address;
    bus_data    = cpu_data;
    bus_read    = cpu_read;
    bus_write   = cpu_write;
    bus_status  = cpu_bus_status;
    case (owner_q)
      2'd1: begin
        bus_address = m_address[ADDR_W-1:0];
        bus_data    = m_data[7:0];
        bus_read    = m_read[0];
        bus_write   = m_write[0];
        bus_status  = m_bus_status[1:0];
      end
      2'd2: begin
        bus_address = m_address[2*ADDR_W-1:ADDR_W];
        bus_data    = m_data[15:8];
        bus_read    = m_read[1];
        bus_write   = m_write[1];
        bus_status  = m_bus_status[3:2];
      end
      2'd3: begin
        bus_address = addr_hold_q;
        bus_data    = data_hold_q;
        bus_read    = 1'b0;
        bus_write   = 1'b0;
        bus_status  = 2'b00;
      end
      default: ;
    endcase
  end

  assign gnt             = gnt_q;
  assign cpu_bus_request = cpu_bus_request_q;
  assign owner           = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: instance A uses CPU_MIN_SLOTS=4, instance B uses 0;
// grant and bus-mux expectations flow through scoreboard queues.
`default_nettype none

module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        clk_ce, reset, cpu_bus_ack;
  logic [1:0]  req;
  logic [23:0] cpu_address;
  logic [7:0]  cpu_data;
  logic        cpu_read, cpu_write;
  logic [1:0]  cpu_bus_status;
  logic [47:0] m_address;
  logic [15:0] m_data;
  logic [1:0]  m_read, m_write;
  logic [3:0]  m_bus_status;

  logic [1:0]  gnt_a, gnt_b, owner_a, owner_b, status_a, status_b;
  logic        breq_a, breq_b, rd_a, rd_b, wr_a, wr_b;
  logic [23:0] addr_a, addr_b;
  logic [7:0]  data_a, data_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  gnt_exp_q[$];
  logic [35:0] bus_exp_q[$];

  always #5 clk = ~clk;

  bus_arbiter #(.CPU_MIN_SLOTS(4), .ADDR_W(24)) u_dut_a (
    .clk(clk), .clk_ce(clk_ce), .reset(reset), .req(req), .gnt(gnt_a),
    .cpu_bus_request(breq_a), .cpu_bus_ack(cpu_bus_ack),
    .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_bus_status(cpu_bus_status),
    .m_address(m_address), .m_data(m_data), .m_read(m_read), .m_write(m_write),
    .m_bus_status(m_bus_status), .bus_address(addr_a), .bus_data(data_a),
    .bus_read(rd_a), .bus_write(wr_a), .bus_status(status_a), .owner(owner_a)
  );

  bus_arbiter #(.CPU_MIN_SLOTS(0), .ADDR_W(24)) u_dut_b (
    .clk(clk), .clk_ce(clk_ce), .reset(reset), .req(req), .gnt(gnt_b),
    .cpu_bus_request(breq_b), .cpu_bus_ack(cpu_bus_ack),
    .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_bus_status(cpu_bus_status),
    .m_address(m_address), .m_data(m_data), .m_read(m_read), .m_write(m_write),
    .m_bus_status(m_bus_status), .bus_address(addr_b), .bus_data(data_b),
    .bus_read(rd_b), .bus_write(wr_b), .bus_status(status_b), .owner(owner_b)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; clk_ce = 1'b1; req = 2'b00; cpu_bus_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  // Waits up to budget ticks for a non-zero grant, then pops the expected one.
  task automatic wait_gnt(input bit use_b, input int budget, output int waited);
    logic [1:0] g, e;
    waited = 0;
    g = 2'b00;
    for (int i = 0; i < budget; i++) begin
      tick();
      waited++;
      g = use_b ? gnt_b : gnt_a;
      if (g != 2'b00) break;
    end
    n_tests++;
    if (gnt_exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL gnt_pop: got %b, expected queue empty", g);
    end else begin
      e = gnt_exp_q.pop_front();
      if (g !== e) begin
        n_fail++;
        $display("FAIL gnt_%s: got %b after %0d ticks, expected %b", use_b ? "b" : "a", g, waited, e);
      end
    end
  endtask

  task automatic check_bus(input bit use_b, input string name);
    logic [35:0] got, e;
    got = use_b ? {addr_b, data_b, rd_b, wr_b, status_b}
                : {addr_a, data_a, rd_a, wr_a, status_a};
    n_tests++;
    if (bus_exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got %h, expected queue empty", name, got);
    end else begin
      e = bus_exp_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", name, got, e);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({gnt_a, breq_a, owner_a} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_a: gnt/req/owner got %b%b%b, expected 00000", gnt_a, breq_a, owner_a);
    end
    n_tests++;
    if ({gnt_b, breq_b, owner_b} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_b: gnt/req/owner got %b%b%b, expected 00000", gnt_b, breq_b, owner_b);
    end
    bus_exp_q.push_back({24'h123456, 8'h5A, 1'b1, 1'b0, 2'b11});
    bus_exp_q.push_back({24'h123456, 8'h5A, 1'b1, 1'b0, 2'b11});
    check_bus(1'b0, "reset_mux_a");
    check_bus(1'b1, "reset_mux_b");
  endtask

  task automatic test_single_m0();
    int w, early;
    do_reset();
    req = 2'b01;
    gnt_exp_q.push_back(2'b01);
    tick();
    n_tests++;
    if (breq_a !== 1'b1) begin
      n_fail++; $display("FAIL single_breq: got %b, expected 1", breq_a);
    end
    early = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (gnt_a !== 2'b00 || breq_a !== 1'b1) early++;
    end
    n_tests++;
    if (early != 0) begin
      n_fail++; $display("FAIL single_pre_ack: %0d bad ticks, expected 0", early);
    end
    cpu_bus_ack = 1'b1;
    wait_gnt(1'b0, 1, w);
    n_tests++;
    if (owner_a !== 2'd1) begin
      n_fail++; $display("FAIL single_owner: got %0d, expected 1", owner_a);
    end
    bus_exp_q.push_back({24'hA0A0A0, 8'h11, 1'b1, 1'b0, 2'b01});
    check_bus(1'b0, "single_mux_m0");
    req = 2'b00;
    tick();
    n_tests++;
    if ({owner_a, gnt_a, breq_a} !== 5'b11_00_1) begin
      n_fail++; $display("FAIL single_turn: owner/gnt/breq got %b%b%b, expected 11001", owner_a, gnt_a, breq_a);
    end
    bus_exp_q.push_back({24'hA0A0A0, 8'h11, 1'b0, 1'b0, 2'b00});
    check_bus(1'b0, "single_mux_turn");
    cpu_bus_ack = 1'b0;
    tick();
    n_tests++;
    if ({owner_a, breq_a} !== 3'b00_0) begin
      n_fail++; $display("FAIL single_back_cpu: owner/breq got %b%b, expected 000", owner_a, breq_a);
    end
    req = 2'b01;
    early = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (breq_a !== 1'b0) early++;
    end
    n_tests++;
    if (early != 0) begin
      n_fail++; $display("FAIL single_slots: request during %0d guard ticks, expected 0", early);
    end
    tick();
    n_tests++;
    if (breq_a !== 1'b1) begin
      n_fail++; $display("FAIL single_after_slots: breq got %b, expected 1", breq_a);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_round_robin();
    int w;
    do_reset();
    cpu_bus_ack = 1'b1;
    req = 2'b11;
    gnt_exp_q.push_back(2'b01);
    wait_gnt(1'b0, 6, w);
    req = 2'b10;
    gnt_exp_q.push_back(2'b10);
    wait_gnt(1'b0, 20, w);
    n_tests++;
    if (w != 8) begin
      n_fail++; $display("FAIL rr_m1_latency: got %0d ticks, expected 8", w);
    end
    req = 2'b00;
    tick(); tick();
    req = 2'b11;
    gnt_exp_q.push_back(2'b01);
    wait_gnt(1'b0, 20, w);
    n_tests++;
    if (w != 6) begin
      n_fail++; $display("FAIL rr_m0_latency: got %0d ticks, expected 6", w);
    end
    req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_direct_handoff();
    int w;
    do_reset();
    cpu_bus_ack = 1'b1;
    req = 2'b11;
    gnt_exp_q.push_back(2'b01);
    wait_gnt(1'b1, 6, w);
    req = 2'b10;
    tick();
    n_tests++;
    if ({owner_b, breq_b} !== 3'b11_1) begin
      n_fail++; $display("FAIL direct_turn: owner/breq got %b%b, expected 111", owner_b, breq_b);
    end
    gnt_exp_q.push_back(2'b10);
    wait_gnt(1'b1, 1, w);
    n_tests++;
    if ({owner_b, breq_b} !== 3'b10_1) begin
      n_fail++; $display("FAIL direct_grant: owner/breq got %b%b, expected 101", owner_b, breq_b);
    end
    bus_exp_q.push_back({24'hBBBBBB, 8'h22, 1'b0, 1'b1, 2'b10});
    check_bus(1'b1, "direct_mux_m1");
    req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_withdraw();
    int bad;
    do_reset();
    req = 2'b10;
    tick();
    n_tests++;
    if (breq_a !== 1'b1) begin
      n_fail++; $display("FAIL withdraw_req: breq got %b, expected 1", breq_a);
    end
    req = 2'b00;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (gnt_a !== 2'b00 || owner_a !== 2'd0) bad++;
    end
    n_tests++;
    if (breq_a !== 1'b0 || bad != 0) begin
      n_fail++; $display("FAIL withdraw: breq got %b with %0d bad ticks, expected 0 and 0", breq_a, bad);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset();
    cpu_bus_ack = 1'b1;
    req = 2'b01;
    gnt_exp_q.push_back(2'b01);
    wait_gnt(1'b0, 6, w);
    clk_ce = 1'b0;
    reset = 1'b1;
    tick();
    n_tests++;
    if ({gnt_a, breq_a, owner_a} !== 5'b0) begin
      n_fail++; $display("FAIL reset_mid: gnt/breq/owner got %b%b%b, expected 00000", gnt_a, breq_a, owner_a);
    end
    reset = 1'b0;
    clk_ce = 1'b1;
    req = 2'b00;
    tick();
  endtask

  task automatic test_gated();
    int bad, w;
    do_reset();
    clk_ce = 1'b0;
    cpu_bus_ack = 1'b1;
    req = 2'b01;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (gnt_a !== 2'b00 || breq_a !== 1'b0 || owner_a !== 2'd0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL gated_hold: %0d ticks changed state, expected 0", bad);
    end
    clk_ce = 1'b1;
    gnt_exp_q.push_back(2'b01);
    wait_gnt(1'b0, 2, w);
    req = 2'b00;
    tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk_ce = 1'b1; reset = 1'b1; cpu_bus_ack = 1'b0; req = 2'b00;
    cpu_address = 24'h123456; cpu_data = 8'h5A; cpu_read = 1'b1;
    cpu_write = 1'b0; cpu_bus_status = 2'b11;
    m_address = {24'hBBBBBB, 24'hA0A0A0}; m_data = {8'h22, 8'h11};
    m_read = 2'b01; m_write = 2'b10; m_bus_status = 4'b10_01;
    test_reset();
    test_single_m0();
    test_round_robin();
    test_direct_handoff();
    test_withdraw();
    test_reset_mid();
    test_gated();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
